// File: rtl/_fifo_r_pkg.sv
// Shared sizing constants and helpers for the _fifo_r show-ahead buffer.
package _fifo_r_pkg;

    localparam int WORD_LENGTH = 16;
    localparam int FIFO_DEPTH  = 4;

    // Address width of the storage array; pointers carry one extra wrap bit.
    function automatic int fifo_addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/_fifo_r_ptr.sv
// Wrap-bit pointer counter: asynchronous active-high clear, +1 on posedge when inc is set.
module _fifo_ptr
    import _fifo_r_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/_fifo_r.sv
// Show-ahead synchronous FIFO with asynchronous reset; Q presents the oldest word while not empty.
// Optional occupancy port 'level' is built only when FIFO_LEVEL_EN is defined.
module _fifo_r
    import _fifo_r_pkg::*;
#(
    parameter  int n     = WORD_LENGTH,
    parameter  int DEPTH = FIFO_DEPTH,
    localparam int A     = fifo_addr_w(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [n-1:0] D,
    output logic         full,
    input  logic         rd_en,
    output logic [n-1:0] Q,
    output logic         empty
`ifdef FIFO_LEVEL_EN
    ,
    output logic [A:0]   level
`endif
);

    logic [n-1:0] mem [DEPTH];
    logic [A:0]   wp;
    logic [A:0]   rp;
    logic         wr_acc;
    logic         rd_acc;

    // Equal indices with differing wrap bits means the writer has lapped the reader.
    assign empty  = (wp == rp);
    assign full   = (wp[A-1:0] == rp[A-1:0]) && (wp[A] != rp[A]);
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    _fifo_ptr #(.W(A + 1)) u_wp (
        .clk (clk),
        .rst (rst),
        .inc (wr_acc),
        .ptr (wp)
    );

    _fifo_ptr #(.W(A + 1)) u_rp (
        .clk (clk),
        .rst (rst),
        .inc (rd_acc),
        .ptr (rp)
    );

    // Storage is deliberately left uncleared; only the pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wp[A-1:0]] <= D;
        end
    end

    assign Q = empty ? '0 : mem[rp[A-1:0]];

`ifdef FIFO_LEVEL_EN
    assign level = wp - rp;
`endif

endmodule

// File: tb/tb__fifo_r.sv
// Scoreboard bench for _fifo_r: a queue-based model predicts status and read data, a monitor compares.
module tb__fifo_r;

    localparam int N     = 16;
    localparam int DEPTH = 4;
    localparam int A     = 2;
    localparam int LW    = A + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en;
    logic         rd_en;
    logic [N-1:0] D;
    logic [N-1:0] Q;
    logic         full;
    logic         empty;
`ifdef FIFO_LEVEL_EN
    logic [A:0]   level;
`endif

    always #5 clk = ~clk;

    _fifo_r #(.n(N), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .D     (D),
        .full  (full),
        .rd_en (rd_en),
        .Q     (Q),
        .empty (empty)
`ifdef FIFO_LEVEL_EN
        ,
        .level (level)
`endif
    );

    typedef struct packed {
        logic          e;
        logic          f;
        logic [LW-1:0] lvl;
        logic [N-1:0]  q;
    } stat_t;

    stat_t        stat_q[$];
    logic [N-1:0] rd_q[$];
    logic [N-1:0] model[$];
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: expectations are derived from the model before it is updated.
    task automatic cycle(input logic w, input logic r, input logic [N-1:0] d);
        stat_t s;
        bit    racc;
        bit    wacc;
        @(posedge clk);
        #1;
        wr_en = w;
        rd_en = r;
        D     = d;
        s.e   = (model.size() == 0);
        s.f   = (model.size() == DEPTH);
        s.lvl = LW'(model.size());
        s.q   = s.e ? '0 : model[0];
        stat_q.push_back(s);
        racc = r && (model.size() > 0);
        wacc = w && (model.size() < DEPTH);
        if (racc) rd_q.push_back(model[0]);
        if (racc) void'(model.pop_front());
        if (wacc) model.push_back(d);
    endtask

    always @(negedge clk) begin : monitor
        stat_t        s;
        logic [N-1:0] w;
        if (stat_q.size() > 0) begin
            s = stat_q.pop_front();
            chk("empty", 32'(empty), 32'(s.e));
            chk("full", 32'(full), 32'(s.f));
            chk("q_show", 32'(Q), 32'(s.q));
`ifdef FIFO_LEVEL_EN
            chk("level", 32'(level), 32'(s.lvl));
`endif
            if (rd_en && !empty) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", 32'(1), 32'(0));
                end else begin
                    w = rd_q.pop_front();
                    chk("rd_data", 32'(Q), 32'(w));
                    $display("READ  Q=%h expected=%h t=%0t", Q, w, $time);
                end
            end
        end
    end

    initial begin
        int pw;
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        D     = '0;
        #1;
        chk("reset_empty", 32'(empty), 32'(1));
        chk("reset_full", 32'(full), 32'(0));
        chk("reset_q", 32'(Q), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Fill, overflow, drain, underflow
        cycle(1, 0, 16'h1111);
        cycle(1, 0, 16'h2222);
        cycle(1, 0, 16'h3333);
        cycle(1, 0, 16'h4444);
        cycle(1, 0, 16'hDEAD);
        for (int i = 0; i < 5; i++) cycle(0, 1, 16'h0000);
        cycle(1, 0, 16'h0001);
        cycle(0, 0, 16'h0000);
        cycle(0, 1, 16'h0000);

        // Empty boundary: write taken, read ignored
        cycle(1, 1, 16'h00AB);
        cycle(0, 0, 16'h0000);
        cycle(1, 0, 16'h00AC);
        // Steady state at level 2 wraps both pointers
        for (int i = 0; i < 10; i++) cycle(1, 1, N'(16'h0100 + i));
        // Full boundary: read taken, write dropped
        cycle(1, 0, 16'h0200);
        cycle(1, 0, 16'h0201);
        cycle(1, 1, 16'hBAD0);
        cycle(0, 0, 16'h0000);
        for (int i = 0; i < 4; i++) cycle(0, 1, 16'h0000);

        // Mid-cycle asynchronous reset with two words stored
        cycle(1, 0, 16'h5555);
        cycle(1, 0, 16'h6666);
        @(posedge clk);
        #1;
        wr_en = 1'b1;
        rd_en = 1'b1;
        D     = 16'hBEEF;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_empty", 32'(empty), 32'(1));
        chk("async_rst_full", 32'(full), 32'(0));
        chk("async_rst_q", 32'(Q), 32'(0));
`ifdef FIFO_LEVEL_EN
        chk("async_rst_level", 32'(level), 32'(0));
`endif
        model.delete();
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        #1;
        chk("rst_drop_write", 32'(empty), 32'(1));
        cycle(1, 0, 16'h0A0A);
        cycle(0, 0, 16'h0000);
        cycle(0, 1, 16'h0000);

        // Randomised traffic with write-heavy, read-heavy and balanced phases
        for (int i = 0; i < 1500; i++) begin
            pw = (i < 500) ? 80 : (i < 1000) ? 20 : 50;
            cycle(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < (100 - pw)), N'($urandom));
        end

        cycle(0, 0, 16'h0000);
        @(negedge clk);
        #1;
        chk("sb_reads_drained", 32'(rd_q.size()), 32'(0));
        chk("sb_status_drained", 32'(stat_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/_fifo_r.md
# _fifo_r

Synchronous first-in first-out buffer with asynchronous reset: stores n-bit words on write and presents the oldest stored word to the consumer in show-ahead fashion. Sits between a producing pipeline stage and a consuming stage of the CPU, for example instruction prefetch feeding decode. It decouples their stall timing without losing or duplicating words.

## Interface
- n, WORD_LENGTH: data width in bits.
- DEPTH, FIFO_DEPTH: number of entries; power of two, ≥2.
- A, log2(DEPTH): derived address width; not overridden.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  write request.
- D  in  n  write data.
- full  out  1  no free entry.
- rd_en  in  1  read (pop) request.
- Q  out  n  oldest stored word; valid while empty=0.
- empty  out  1  no stored word.
- level  out  A+1  occupancy, 0..DEPTH (only with FIFO_LEVEL_EN).

## Operation
- State: storage array mem[DEPTH], write pointer wp and read pointer rp, each A+1 bits (MSB is wrap bit).
- empty = (wp == rp).
- full = (wp[A-1:0] == rp[A-1:0]) and (wp[A] != rp[A]).
- Accepted write: wr_en=1 and full=0. On posedge: mem[wp[A-1:0]] <= D, wp <= wp+1.
- Accepted read: rd_en=1 and empty=0. On posedge: rp <= rp+1.
- Write while full: ignored. No storage or pointer change, even if rd_en=1 in the same cycle.
- Read while empty: ignored. No pointer change, even if wr_en=1 in the same cycle. The write is still accepted.
- Simultaneous accepted read and write (0 < occupancy < DEPTH): both take effect; occupancy is unchanged.
- Pointers increment modulo 2^(A+1). Wrap-around is natural; there is no special case.
- Q = mem[rp[A-1:0]] when empty=0, else all zeros. Combinational from state only, never from D.
- Reset, asserted at any time including mid-operation: wp=rp=0 immediately, so empty=1, full=0, Q=0, level=0. mem contents are not cleared, and pending requests are discarded. Operation resumes on the first posedge after rst deasserts.

## Timing
- Write accepted at edge k: empty falls and Q shows the word right after edge k. Write-to-read latency is 1 cycle.
- Read accepted at edge k: Q advances to the next word, or to 0 with empty=1, right after edge k.
- full and empty are registered-state functions. No input-to-output combinational path exists except via pointers.
- Throughput: one write and one read per cycle sustained when occupancy is between 0 and DEPTH.
- Asynchronous reset effect is immediate. Release is synchronous to the next posedge.

## Configuration
- Macro FIFO_LEVEL_EN.
- Defined: port level is present and equals wp - rp, computed modulo 2^(A+1) over A+1 bits. Value 0 when empty, DEPTH when full, reset value 0.
- Undefined: port level is absent. No extra logic is generated; all other behaviour is identical.

## Structure
- constants.vh gains FIFO_DEPTH (default 4) beside WORD_LENGTH.
- Sub-module _fifo_ptr(clk, rst, inc, ptr): an (A+1)-bit counter with asynchronous active-high reset to 0, incrementing on posedge when inc=1. Instantiated twice, once for wp and once for rp.
- The storage array is not reset and lives in _fifo_r.

## Test plan
- Reset: assert rst mid-cycle with 2 words stored → immediately empty=1, full=0, Q=0, level=0. After release, the first Q equals the first new write.
- Fill and drain, DEPTH=4, n=16: write 0x1111, 0x2222, 0x3333, 0x4444 → full=1, level=4. Then 4 reads return Q in order 0x1111..0x4444, then empty=1 and Q=0.
- Overflow and underflow: a 5th write of 0xDEAD while full is dropped, so the drain yields 4 words with no 0xDEAD. A read while empty leaves rp unchanged, and the next write 0x0001 appears on Q.
- Simultaneous read and write at level 2 for 10 cycles → level stays 2, output order is preserved, and pointers wrap past index 3 correctly.
- Full-boundary simultaneous access: full, wr_en=rd_en=1 → read accepted, write dropped, level=3. Empty-boundary simultaneous access: empty, wr_en=rd_en=1 with D=0x00AB → write accepted, Q=0x00AB, level=1.
- Build once without FIFO_LEVEL_EN → the same scenarios pass on full, empty and Q.
